// File: rtl/lza_norm_pkg.sv
// Shared types and sizing helpers for the LZA normalization controller.
package lza_norm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Wide enough to hold any count 0..DATA_WIDTH plus one saturating bit.
    function automatic int shift_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/lza_norm_ctrl_if.sv
// Operand/result handshake bundle for lza_norm_ctrl, plus the FSM state for observation.
interface lza_norm_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = lza_norm_pkg::shift_width(DATA_WIDTH)
);
    // Both sides use valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both 1; the sender holds valid and data until then.
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  mant_in;
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic                   nshift_correct;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  mant_out;
    logic [SHIFT_WIDTH-1:0] shift_total;
    logic                   out_zero;
    logic                   norm_err;

    lza_norm_pkg::state_t   dbg_state;

    modport slave (
        input  in_valid, mant_in, shift_amt, nshift_correct, out_ready,
        output in_ready, out_valid, mant_out, shift_total, out_zero, norm_err, dbg_state
    );

    modport master (
        output in_valid, mant_in, shift_amt, nshift_correct, out_ready,
        input  in_ready, out_valid, mant_out, shift_total, out_zero, norm_err, dbg_state
    );
endinterface

// File: rtl/lza_norm_shifter.sv
// Combinational logarithmic left barrel shifter, zero-fill; amounts >= DATA_WIDTH give 0.
module lza_norm_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = lza_norm_pkg::shift_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHIFT_WIDTH-1:0] amount,
    output logic [DATA_WIDTH-1:0]  result
);
    localparam int LOG = $clog2(DATA_WIDTH);

    logic [LOG:0][DATA_WIDTH-1:0] stage;

    always_comb begin
        stage[0] = data;
        for (int i = 0; i < LOG; i++) begin
            stage[i+1] = amount[i] ? (stage[i] << (1 << i)) : stage[i];
        end
        result = (amount >= SHIFT_WIDTH'(DATA_WIDTH)) ? '0 : stage[LOG];
    end
endmodule

// File: rtl/lza_norm_ctrl.sv
// Post-adder normalization sequencer: coarse LZA shift, optional 1-bit correction,
// then holds the result until the exponent stage accepts it.
module lza_norm_ctrl
    import lza_norm_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = shift_width(DATA_WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    lza_norm_ctrl_if.slave bus
);
    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  mant_r;
    logic [SHIFT_WIDTH-1:0] shamt_r;
    logic                   corr_r;
    logic [SHIFT_WIDTH-1:0] total_r;
    logic                   zero_r;
    logic                   err_r;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   sat;

    lza_norm_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_shifter (
        .data  (mant_r),
        .amount(shamt_r),
        .result(shifted)
    );

    // A zero operand or an out-of-range count both collapse to a clean zero result.
    assign sat = (shamt_r >= SHIFT_WIDTH'(DATA_WIDTH)) || (mant_r == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   state_next = (corr_r && !sat) ? CORRECT : DONE;
            CORRECT: state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_r  <= '0;
            shamt_r <= '0;
            corr_r  <= 1'b0;
            total_r <= '0;
            zero_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    mant_r  <= bus.mant_in;
                    shamt_r <= bus.shift_amt;
                    corr_r  <= bus.nshift_correct;
                    zero_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
                SHIFT: if (sat) begin
                    mant_r  <= '0;
                    total_r <= '0;
                    zero_r  <= 1'b1;
                    err_r   <= 1'b0;
                end else begin
                    mant_r  <= shifted;
                    total_r <= shamt_r;
                    // Only final when no correction follows; CORRECT overwrites it otherwise.
                    err_r   <= ~shifted[DATA_WIDTH-1];
                end
                CORRECT: begin
                    mant_r  <= {mant_r[DATA_WIDTH-2:0], 1'b0};
                    total_r <= total_r + SHIFT_WIDTH'(1);
                    err_r   <= ~mant_r[DATA_WIDTH-2];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.mant_out    = mant_r;
    assign bus.shift_total = total_r;
    assign bus.out_zero    = zero_r;
    assign bus.norm_err    = err_r;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_lza_norm_ctrl.sv
// Directed bench for lza_norm_ctrl: vector table plus backpressure and mid-flight reset sequences.
module tb_lza_norm_ctrl;
    import lza_norm_pkg::*;

    typedef struct {
        logic [7:0] mant;
        logic [3:0] amt;
        logic       corr;
        logic [7:0] exp_mant;
        logic [3:0] exp_total;
        logic       exp_zero;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    lza_norm_ctrl_if #(.DATA_WIDTH(8), .SHIFT_WIDTH(4)) bus ();

    lza_norm_ctrl #(.DATA_WIDTH(8), .SHIFT_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"},   32'(bus.out_valid), 32'd0);
        check({tag, "_mant_out"},    32'(bus.mant_out), 32'd0);
        check({tag, "_shift_total"}, 32'(bus.shift_total), 32'd0);
        check({tag, "_out_zero"},    32'(bus.out_zero), 32'd0);
        check({tag, "_norm_err"},    32'(bus.norm_err), 32'd0);
        check({tag, "_state"},       32'(bus.dbg_state), 32'(IDLE));
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns #1 after the accept edge.
    task automatic send(input logic [7:0] mant, input logic [3:0] amt, input logic corr);
        check("pre_accept_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid       = 1'b1;
        bus.mant_in        = mant;
        bus.shift_amt      = amt;
        bus.nshift_correct = corr;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("accept_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("accept_flags_clear", 32'({bus.out_zero, bus.norm_err}), 32'd0);
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.out_ready = 1'b1;
        send(v.mant, v.amt, v.corr);
        wait_valid(lat);
        check({tag, "_latency"},     32'(lat), 32'(v.exp_lat));
        check({tag, "_mant_out"},    32'(bus.mant_out), 32'(v.exp_mant));
        check({tag, "_shift_total"}, 32'(bus.shift_total), 32'(v.exp_total));
        check({tag, "_out_zero"},    32'(bus.out_zero), 32'(v.exp_zero));
        check({tag, "_norm_err"},    32'(bus.norm_err), 32'(v.exp_err));
        @(posedge clk); #1;
        check({tag, "_back_idle"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
    endtask

    vec_t vecs [0:13];

    initial begin
        int lat;
        vecs[0]  = '{8'h16, 4'd3,  1'b0, 8'hB0, 4'd3, 1'b0, 1'b0, 2};
        vecs[1]  = '{8'h0B, 4'd3,  1'b1, 8'hB0, 4'd4, 1'b0, 1'b0, 3};
        vecs[2]  = '{8'h0B, 4'd3,  1'b0, 8'h58, 4'd3, 1'b0, 1'b1, 2};
        vecs[3]  = '{8'h00, 4'd5,  1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 2};
        vecs[4]  = '{8'hFF, 4'd9,  1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 2};
        vecs[5]  = '{8'hFF, 4'd8,  1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 2};
        vecs[6]  = '{8'h80, 4'd0,  1'b0, 8'h80, 4'd0, 1'b0, 1'b0, 2};
        vecs[7]  = '{8'h01, 4'd7,  1'b0, 8'h80, 4'd7, 1'b0, 1'b0, 2};
        vecs[8]  = '{8'h01, 4'd6,  1'b1, 8'h80, 4'd7, 1'b0, 1'b0, 3};
        vecs[9]  = '{8'h03, 4'd6,  1'b1, 8'h80, 4'd7, 1'b0, 1'b0, 3};
        vecs[10] = '{8'h00, 4'd0,  1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 2};
        vecs[11] = '{8'h01, 4'd0,  1'b1, 8'h02, 4'd1, 1'b0, 1'b1, 3};
        vecs[12] = '{8'h3C, 4'd1,  1'b0, 8'h78, 4'd1, 1'b0, 1'b1, 2};
        vecs[13] = '{8'hA5, 4'd15, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 2};

        bus.in_valid       = 1'b0;
        bus.mant_in        = '0;
        bus.shift_amt      = '0;
        bus.nshift_correct = 1'b0;
        bus.out_ready      = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Backpressure: result held for 4 cycles while a new operand waits
        bus.out_ready = 1'b0;
        send(8'h16, 4'd3, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd2);
        bus.in_valid       = 1'b1;
        bus.mant_in        = 8'h3F;
        bus.shift_amt      = 4'd2;
        bus.nshift_correct = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready), 32'd0);
            check("bp_hold", 32'({bus.mant_out, bus.shift_total, bus.out_zero, bus.norm_err}),
                  32'({8'hB0, 4'd3, 1'b0, 1'b0}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_pending_accepted", 32'(bus.dbg_state), 32'(SHIFT));
        wait_valid(lat);
        check("bp_next_latency", 32'(lat), 32'd2);
        check("bp_next_result", 32'({bus.mant_out, bus.shift_total, bus.out_zero, bus.norm_err}),
              32'({8'hFC, 4'd2, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Reset while in CORRECT
        send(8'h0B, 4'd3, 1'b1);
        @(posedge clk); #1;
        check("mid_state_correct", 32'(bus.dbg_state), 32'(CORRECT));
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat++;
        end
        check("mid_no_spurious_valid", 32'(lat), 32'd0);
        check("mid_in_ready_after", 32'(bus.in_ready), 32'd1);
        run_vec(vecs[1], 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lza_norm_ctrl.md
Name: lza_norm_ctrl

Overview:
- Sequences the post-adder normalization step of the LZA datapath.
- Accepts an unnormalized mantissa, the LZA-anticipated left-shift count and the detection tree's nshift_correct flag. Applies the coarse shift, then conditionally a 1-bit correction shift.
- Returns the normalized mantissa, the total shift for exponent adjustment, and status flags.
- Sits between the LZA/detection-tree stage and exponent update, with valid/ready on both sides.

Parameters:
- DATA_WIDTH, 8, mantissa width in bits.
- SHIFT_WIDTH, $clog2(DATA_WIDTH)+1, width of the shift-count input and output.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  controller can accept an operand
- mant_in  input  DATA_WIDTH  unnormalized mantissa
- shift_amt  input  SHIFT_WIDTH  anticipated left-shift count
- nshift_correct  input  1  1 = anticipation one short, one extra left shift is required
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- mant_out  output  DATA_WIDTH  normalized mantissa
- shift_total  output  SHIFT_WIDTH  total left shift applied
- out_zero  output  1  result mantissa is zero
- norm_err  output  1  result is nonzero but mant_out MSB = 0 (anticipation error not covered by correction)

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - mant_out = 0, shift_total = 0, out_zero = 0, norm_err = 0.
  - All internal registers are cleared.
- FSM states: IDLE, SHIFT, CORRECT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register mant_in, shift_amt and nshift_correct, then go to SHIFT.
  - in_ready is 0 in every other state. There is no skid buffer; one operand is in flight at a time.
- SHIFT (one cycle):
  - mant_r <= mant_r << shift_amt_r, and shift_total <= shift_amt_r.
  - Saturation: if shift_amt_r >= DATA_WIDTH, or mant_r == 0, then mant_r <= 0, shift_total <= 0, out_zero <= 1, and the correction is skipped.
  - Next state is CORRECT if nshift_correct_r & ~zero, otherwise DONE.
- CORRECT (one cycle):
  - mant_r <= mant_r << 1, and shift_total <= shift_total + 1.
  - shift_total + 1 cannot overflow SHIFT_WIDTH, because shift_amt_r <= DATA_WIDTH-1 on this path.
  - Next state is DONE.
- DONE:
  - out_valid = 1. mant_out, shift_total, out_zero and norm_err are held stable while out_ready = 0.
  - norm_err = ~out_zero & ~mant_out[DATA_WIDTH-1], evaluated on the final value.
  - On out_ready, go to IDLE; in_ready rises the following cycle.
  - The out_zero and norm_err flags are cleared on the next acceptance in IDLE.
- Latency from input accept edge to out_valid: 2 cycles without correction, 3 cycles with correction.
- Throughput: one result per 3 or 4 cycles, counting the return to IDLE.
- in_valid while in_ready = 0 is ignored. Upstream must hold its data until accepted.
- Reset mid-operation aborts the in-flight operand immediately. No result is emitted.
- out_valid never asserts without a preceding accept.

Decomposition:
- Package lza_norm_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, CORRECT=2'd2, DONE=2'd3);
  - the helper function for SHIFT_WIDTH.
- Sub-module lza_norm_shifter: purely combinational logarithmic left barrel shifter.
  - Interface: DATA_WIDTH in, SHIFT_WIDTH amount, zero-fill.
  - Amounts >= DATA_WIDTH produce 0.
  - Instantiated once for the SHIFT state. The CORRECT state uses a fixed 1-bit shift in the controller.

Test Plan (DATA_WIDTH=8, SHIFT_WIDTH=4):
- Basic shift: mant_in=8'b0001_0110, shift_amt=3, nshift_correct=0 -> after 2 cycles mant_out=8'b1011_0000, shift_total=3, out_zero=0, norm_err=0.
- Correction path: mant_in=8'b0000_1011, shift_amt=3, nshift_correct=1 -> after 3 cycles mant_out=8'b1011_0000, shift_total=4, norm_err=0.
- Missed correction: mant_in=8'b0000_1011, shift_amt=3, nshift_correct=0 -> mant_out=8'b0101_1000, shift_total=3, norm_err=1.
- Zero and saturation cases, each -> mant_out=0, shift_total=0, out_zero=1, latency 2 (no CORRECT state):
  - mant_in=0, shift_amt=5, nshift_correct=1;
  - mant_in=8'hFF, shift_amt=9.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable, out_valid=1, in_ready=0, and a pending in_valid is not accepted; raise out_ready -> IDLE, next operand accepted one cycle later.
- Reset mid-operation: assert rst during CORRECT -> all outputs at reset values immediately, in_ready=1 after release, and no spurious out_valid.
